// File: rtl/gpio_axil_banked.sv
// gpio_axil_banked: AXI-Lite GPIO controller with pins grouped into 32-bit banks.
// Registers per bank: DIR, OUT, SET/CLR/TGL (write-1 modifiers of OUT), IN
// (synchronised pins), IE_RISE, IE_FALL and STATUS (write-1-to-clear).
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   gpio_in            raw pad inputs
//   gpio_out           output values
//   gpio_dir_out       direction, 1 = output
//   gpio_in_sync       inputs after the SyncStages-deep synchroniser
//   interrupt          OR of all STATUS bits
//   axi_lite_req_i/o   AXI-Lite slave request / response

package gpio_axil_banked_pkg;
    typedef struct packed { logic [31:0] addr; } axil_ax_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } axil_w_t;
    typedef struct packed { logic [1:0] resp; } axil_b_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; } axil_r_t;
    typedef struct packed {
        axil_ax_t aw; logic aw_valid;
        axil_w_t  w;  logic w_valid;
        logic     b_ready;
        axil_ax_t ar; logic ar_valid;
        logic     r_ready;
    } axil_req_t;
    typedef struct packed {
        logic    aw_ready; logic w_ready;
        axil_b_t b;        logic b_valid;
        logic    ar_ready;
        axil_r_t r;        logic r_valid;
    } axil_rsp_t;
endpackage

module gpio_axil_banked #(
    parameter int unsigned NrGPIOs    = 32,
    parameter int unsigned SyncStages = 2,
    parameter type axi_lite_req_t = gpio_axil_banked_pkg::axil_req_t,
    parameter type axi_lite_rsp_t = gpio_axil_banked_pkg::axil_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NrGPIOs-1:0]  gpio_in,
    output logic [NrGPIOs-1:0]  gpio_out,
    output logic [NrGPIOs-1:0]  gpio_dir_out,
    output logic [NrGPIOs-1:0]  gpio_in_sync,
    output logic                interrupt,
    input  axi_lite_req_t       axi_lite_req_i,
    output axi_lite_rsp_t       axi_lite_rsp_o
);
    localparam int unsigned NrBanks = (NrGPIOs + 31) / 32;
    localparam int unsigned W       = NrBanks * 32;
    localparam logic [5:0]  NB6     = 6'(NrBanks);

    localparam logic [4:0] REG_DIR = 5'd0, REG_OUT = 5'd1, REG_SET = 5'd2,
                           REG_CLR = 5'd3, REG_TGL = 5'd4, REG_IN = 5'd5,
                           REG_IE_RISE = 5'd6, REG_IE_FALL = 5'd7, REG_STATUS = 5'd8;

    // Bits past NrGPIOs in the last bank are never written.
    function automatic logic [W-1:0] impl_mask();
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (i < NrGPIOs);
        return m;
    endfunction
    localparam logic [NrBanks-1:0][31:0] IMPL = impl_mask();

    logic [NrBanks-1:0][31:0] dir_q, out_q, ie_rise_q, ie_fall_q, status_q;
    logic [SyncStages-1:0][NrGPIOs-1:0] sync_q;
    logic [NrGPIOs-1:0] prev_q;
    logic [NrBanks-1:0][31:0] sync_w, prev_w, rise, fall;

    logic       b_valid_q, r_valid_q;
    logic [1:0] b_resp_q, r_resp_q;
    logic [31:0] r_data_q;

    // ---------------- synchroniser and edge detection ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SyncStages-1];
        end
    end

    assign sync_w = W'(sync_q[SyncStages-1]);
    assign prev_w = W'(prev_q);
    assign rise   = sync_w & ~prev_w;
    assign fall   = ~sync_w & prev_w;

    // ---------------- write decode ----------------
    logic [4:0]  w_reg, w_bank, r_reg, r_bank;
    logic        w_err, r_err, w_fire, ar_fire;
    logic [31:0] w_bytes;
    logic [NrBanks-1:0]       w_hit;
    logic [NrBanks-1:0][31:0] w_keep, w_bits, w1c;

    assign w_reg  = axi_lite_req_i.aw.addr[11:7];
    assign w_bank = axi_lite_req_i.aw.addr[6:2];
    assign r_reg  = axi_lite_req_i.ar.addr[11:7];
    assign r_bank = axi_lite_req_i.ar.addr[6:2];
    assign w_err  = ({1'b0, w_bank} >= NB6) || (w_reg > REG_STATUS);
    assign r_err  = ({1'b0, r_bank} >= NB6) || (r_reg > REG_STATUS);

    // AW and W are only taken as a pair, and only with no B outstanding.
    assign w_fire  = !rst_i && axi_lite_req_i.aw_valid && axi_lite_req_i.w_valid && !b_valid_q;
    assign ar_fire = !rst_i && axi_lite_req_i.ar_valid && !r_valid_q;

    assign w_bytes = {{8{axi_lite_req_i.w.strb[3]}}, {8{axi_lite_req_i.w.strb[2]}},
                      {8{axi_lite_req_i.w.strb[1]}}, {8{axi_lite_req_i.w.strb[0]}}};

    always_comb begin
        for (int b = 0; b < NrBanks; b++) begin
            w_hit[b]  = w_fire && !w_err && (w_bank == 5'(b));
            w_keep[b] = w_bytes & IMPL[b];                     // bits this write may touch
            w_bits[b] = axi_lite_req_i.w.data & w_keep[b];     // bits written as 1
            w1c[b]    = (w_hit[b] && w_reg == REG_STATUS) ? w_bits[b] : 32'h0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_q     <= '0;
            out_q     <= '0;
            ie_rise_q <= '0;
            ie_fall_q <= '0;
            status_q  <= '0;
        end else begin
            for (int b = 0; b < NrBanks; b++) begin
                if (w_hit[b]) begin
                    case (w_reg)
                        REG_DIR:     dir_q[b]     <= (dir_q[b] & ~w_keep[b]) | w_bits[b];
                        REG_OUT:     out_q[b]     <= (out_q[b] & ~w_keep[b]) | w_bits[b];
                        REG_SET:     out_q[b]     <= out_q[b] | w_bits[b];
                        REG_CLR:     out_q[b]     <= out_q[b] & ~w_bits[b];
                        REG_TGL:     out_q[b]     <= out_q[b] ^ w_bits[b];
                        REG_IE_RISE: ie_rise_q[b] <= (ie_rise_q[b] & ~w_keep[b]) | w_bits[b];
                        REG_IE_FALL: ie_fall_q[b] <= (ie_fall_q[b] & ~w_keep[b]) | w_bits[b];
                        default: ;
                    endcase
                end
                // New events are OR-ed in after the clear so a same-cycle set wins.
                status_q[b] <= (status_q[b] & ~w1c[b])
                             | (rise[b] & ie_rise_q[b]) | (fall[b] & ie_fall_q[b]);
            end
        end
    end

    // ---------------- read mux ----------------
    logic [31:0] rd_data;
    always_comb begin
        rd_data = 32'h0;
        for (int b = 0; b < NrBanks; b++) begin
            if (!r_err && r_bank == 5'(b)) begin
                case (r_reg)
                    REG_DIR:     rd_data = dir_q[b];
                    REG_OUT:     rd_data = out_q[b];
                    REG_IN:      rd_data = sync_w[b];
                    REG_IE_RISE: rd_data = ie_rise_q[b];
                    REG_IE_FALL: rd_data = ie_fall_q[b];
                    REG_STATUS:  rd_data = status_q[b];
                    default:     rd_data = 32'h0;
                endcase
            end
        end
    end

    // ---------------- response channels ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_valid_q <= 1'b0;
            b_resp_q  <= 2'b00;
            r_valid_q <= 1'b0;
            r_resp_q  <= 2'b00;
            r_data_q  <= 32'h0;
        end else begin
            if (w_fire) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= w_err ? 2'b10 : 2'b00;
            end else if (axi_lite_req_i.b_ready) begin
                b_valid_q <= 1'b0;
            end
            if (ar_fire) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_data;
                r_resp_q  <= r_err ? 2'b10 : 2'b00;
            end else if (axi_lite_req_i.r_ready) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        axi_lite_rsp_o          = '0;
        axi_lite_rsp_o.aw_ready = w_fire;
        axi_lite_rsp_o.w_ready  = w_fire;
        axi_lite_rsp_o.b.resp   = b_resp_q;
        axi_lite_rsp_o.b_valid  = b_valid_q;
        axi_lite_rsp_o.ar_ready = !rst_i && !r_valid_q;
        axi_lite_rsp_o.r.data   = r_data_q;
        axi_lite_rsp_o.r.resp   = r_resp_q;
        axi_lite_rsp_o.r_valid  = r_valid_q;
    end

    logic [W-1:0] out_flat, dir_flat;
    assign out_flat     = out_q;
    assign dir_flat     = dir_q;
    assign gpio_out     = out_flat[NrGPIOs-1:0];
    assign gpio_dir_out = dir_flat[NrGPIOs-1:0];
    assign gpio_in_sync = sync_q[SyncStages-1];
    assign interrupt    = |status_q;

    logic unused_bits;
    assign unused_bits = ^{axi_lite_req_i.aw.addr[31:12], axi_lite_req_i.aw.addr[1:0],
                           axi_lite_req_i.ar.addr[31:12], axi_lite_req_i.ar.addr[1:0],
                           out_flat, dir_flat, sync_w, prev_w};
endmodule
